ex: RTL and testbench



---
 rtl/ex.sv | 217 +++++++++++++++++++++
 tb/tb_ex.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex.sv
// rtl/ex.sv - MIPS execute stage: logic/shift ALU plus multi-cycle restoring divider
//
// Optional feature macro: EX_DIV_EN builds the DIV/DIVU divider FSM and HI/LO outputs.
// Without it DIV/DIVU act as NOPs and the divider outputs are tied to zero.
//
// Ports:
//   clk         pipeline clock, rising edge
//   rst         synchronous reset, active-low
//   aluop_i     operation subtype
//   alusel_i    result class (NOP / LOGIC / SHIFT)
//   reg1_i      operand 1 (shift amount, dividend)
//   reg2_i      operand 2 (shifted value, divisor)
//   wd_i        destination register address
//   wreg_i      destination write enable
//   annul_i     cancel an in-flight divide
//   wd_o        destination address to EX/MEM and ID forwarding
//   wreg_o      write enable to EX/MEM and ID forwarding
//   wdata_o     result to EX/MEM and ID forwarding
//   hilo_we_o   HI/LO write strobe
//   hi_o        remainder
//   lo_o        quotient
//   stallreq_o  stall request to the pipeline controller

module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    logic        is_div;
    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [4:0]  shamt;

    assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign shamt  = reg1_i[4:0];

    always_comb begin
        logic_res = 32'd0;
        case (aluop_i)
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = 32'd0;
        endcase
    end

    always_comb begin
        shift_res = 32'd0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << shamt;
            EXE_SRL_OP: shift_res = reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> shamt);
            default:    shift_res = 32'd0;
        endcase
    end

    // Divides never write the GPR file; their results go to HI/LO only.
    always_comb begin
        wd_o    = 5'd0;
        wreg_o  = 1'b0;
        wdata_o = 32'd0;
        if (rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i & ~is_div;
            if (!is_div) begin
                case (alusel_i)
                    EXE_RES_LOGIC: wdata_o = logic_res;
                    EXE_RES_SHIFT: wdata_o = shift_res;
                    default:       wdata_o = 32'd0;
                endcase
            end
        end
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_ON    = 2'd1,
        DIV_DZERO = 2'd2,
        DIV_END   = 2'd3
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // [64:33] partial remainder, [32:1] unconsumed dividend bits, quotient bits shift in at [0].
    logic [64:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;

    logic        stall_c;
    logic        hilo_we_c;
    logic        signed_op;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [33:0] diff;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;

    assign signed_op = (aluop_i == EXE_DIV_OP);
    assign op1_abs   = (signed_op && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign op2_abs   = (signed_op && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    // The minuend is 33 bits wide: 2*remainder+bit can exceed 32 bits for divisors above 2^31.
    assign diff      = {1'b0, rem_q[64:32]} - {2'b00, divisor_q};
    assign quot_raw  = rem_q[31:0];
    assign rem_raw   = rem_q[64:33];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 65'd0;
            divisor_q <= 32'd0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        stall_c   = 1'b0;
        hilo_we_c = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (is_div && !annul_i) begin
                    stall_c   = 1'b1;
                    sign1_d   = signed_op & reg1_i[31];
                    sign2_d   = signed_op & reg2_i[31];
                    divisor_d = op2_abs;
                    rem_d     = {32'd0, op1_abs, 1'b0};
                    cnt_d     = 6'd0;
                    state_d   = (reg2_i == 32'd0) ? DIV_DZERO : DIV_ON;
                end
            end
            DIV_ON: begin
                stall_c = 1'b1;
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    if (diff[33]) begin
                        rem_d = {rem_q[63:0], 1'b0};
                    end else begin
                        rem_d = {diff[31:0], rem_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DIV_END;
                    end
                end
            end
            DIV_DZERO: begin
                stall_c = 1'b1;
                rem_d   = 65'd0;
                state_d = DIV_END;
            end
            DIV_END: begin
                hilo_we_c = 1'b1;
                state_d   = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign stallreq_o = rst & stall_c;
    assign hilo_we_o  = rst & hilo_we_c;
    assign lo_o = (rst && hilo_we_c) ? ((sign1_q ^ sign2_q) ? (~quot_raw + 32'd1) : quot_raw) : 32'd0;
    assign hi_o = (rst && hilo_we_c) ? (sign1_q ? (~rem_raw + 32'd1) : rem_raw) : 32'd0;
`else
    logic unused_div;
    assign unused_div = &{1'b0, clk, annul_i};
    assign stallreq_o = 1'b0;
    assign hilo_we_o  = 1'b0;
    assign hi_o       = 32'd0;
    assign lo_o       = 32'd0;
`endif

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - self-checking scoreboard bench for the ex execute stage

module tb_ex;

    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [63:0] div_q[$];

    always #5 clk = ~clk;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .annul_i    (annul_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .hilo_we_o  (hilo_we_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(a[4:0]);
        r  = 32'd0;
        if (sel == SEL_LOGIC) begin
            if (op == OP_AND) r = a & b;
            if (op == OP_OR)  r = a | b;
            if (op == OP_XOR) r = a ^ b;
            if (op == OP_NOR) r = ~(a | b);
        end else if (sel == SEL_SHIFT) begin
            for (int i = 0; i < 32; i++) begin
                if (op == OP_SLL) r[i] = (i >= sh) ? b[i - sh] : 1'b0;
                if (op == OP_SRL) r[i] = (i + sh <= 31) ? b[i + sh] : 1'b0;
                if (op == OP_SRA) r[i] = (i + sh <= 31) ? b[i + sh] : b[31];
            end
        end
        return r;
    endfunction

    // Combinational op: push expected, sample one step later, pop and compare.
    task automatic apply_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'd5;
        wreg_i   = 1'b1;
        exp_q.push_back(exp);
        #1;
        expect_eq({tag, "_wdata"}, wdata_o, exp_q.pop_front());
        expect_eq({tag, "_wd"}, 32'(wd_o), 32'd5);
        expect_eq({tag, "_wreg"}, 32'(wreg_o), 32'd1);
        expect_eq({tag, "_stall"}, 32'(stallreq_o), 32'd0);
        next_cycle();
    endtask

    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int exp_stalls);
        int          stalls;
        logic        done;
        logic        bad;
        logic [63:0] e;
        aluop_i  = op;
        alusel_i = SEL_NOP;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'd3;
        wreg_i   = 1'b1;
        annul_i  = 1'b0;
        div_q.push_back({exp_hi, exp_lo});
        stalls = 0;
        done   = 1'b0;
        bad    = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (wreg_o !== 1'b0) bad = 1'b1;
            if (hilo_we_o === 1'b1) begin
                e = div_q.pop_front();
                expect_eq({tag, "_hi"}, hi_o, e[63:32]);
                expect_eq({tag, "_lo"}, lo_o, e[31:0]);
                expect_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
                expect_eq({tag, "_end_stall"}, 32'(stallreq_o), 32'd0);
                done = 1'b1;
            end else begin
                if (stallreq_o === 1'b1) stalls++;
                if (hi_o !== 32'd0 || lo_o !== 32'd0) bad = 1'b1;
            end
            next_cycle();
        end
        expect_eq({tag, "_completed"}, 32'(done), 32'd1);
        expect_eq({tag, "_quiet_outputs"}, 32'(bad), 32'd0);
    endtask

    task automatic abort_div(input string tag, input logic use_rst);
        logic bad;
        aluop_i  = OP_DIVU;
        alusel_i = SEL_NOP;
        reg1_i   = 32'd100;
        reg2_i   = 32'd7;
        annul_i  = 1'b0;
        // Issue cycle is cycle 0; cycle 11 is ON iteration 10.
        for (int c = 0; c < 11; c++) next_cycle();
        if (use_rst) rst = 1'b0;
        else annul_i = 1'b1;
        #1;
        expect_eq({tag, "_abort_cycle_stall"}, 32'(stallreq_o), use_rst ? 32'd0 : 32'd1);
        next_cycle();
        rst     = 1'b1;
        annul_i = 1'b0;
        aluop_i = OP_OR;
        #1;
        expect_eq({tag, "_idle_stall"}, 32'(stallreq_o), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            #1;
            if (hilo_we_o !== 1'b0 || stallreq_o !== 1'b0) bad = 1'b1;
        end
        expect_eq({tag, "_no_hilo"}, 32'(bad), 32'd0);
        next_cycle();
    endtask

    initial begin
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        bad;

        rst      = 1'b0;
        aluop_i  = OP_OR;
        alusel_i = SEL_LOGIC;
        reg1_i   = 32'h0000FF00;
        reg2_i   = 32'h00F000F0;
        wd_i     = 5'd5;
        wreg_i   = 1'b1;
        annul_i  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            expect_eq("reset_wdata", wdata_o, 32'd0);
            expect_eq("reset_any_output",
                      32'(|{wd_o, wreg_o, hilo_we_o, hi_o, lo_o, stallreq_o}), 32'd0);
        end
        rst = 1'b1;

        apply_op("or",        OP_OR,  SEL_LOGIC, 32'h0000FF00, 32'h00F000F0, 32'h00F0FFF0);
        apply_op("and",       OP_AND, SEL_LOGIC, 32'h0000FF00, 32'h00F000F0, 32'h00000000);
        apply_op("xor",       OP_XOR, SEL_LOGIC, 32'h0F0FFF00, 32'h00F000F0, 32'h0FFFFFF0);
        apply_op("nor",       OP_NOR, SEL_LOGIC, 32'h0000FF00, 32'h00F000F0, 32'hFF0F000F);
        apply_op("sra",       OP_SRA, SEL_SHIFT, 32'd4,        32'h80000010, 32'hF8000001);
        apply_op("sll",       OP_SLL, SEL_SHIFT, 32'd4,        32'h80000010, 32'h00000100);
        apply_op("srl",       OP_SRL, SEL_SHIFT, 32'd4,        32'h80000010, 32'h08000001);
        apply_op("sra_amt36", OP_SRA, SEL_SHIFT, 32'd36,       32'h80000010, 32'hF8000001);
        apply_op("sra_31",    OP_SRA, SEL_SHIFT, 32'd31,       32'h80000000, 32'hFFFFFFFF);
        apply_op("sel_nop",   OP_OR,  SEL_NOP,   32'h12345678, 32'h9ABCDEF0, 32'h00000000);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(6, 0))
                0: op = OP_AND;
                1: op = OP_OR;
                2: op = OP_XOR;
                3: op = OP_NOR;
                4: op = OP_SLL;
                5: op = OP_SRL;
                default: op = OP_SRA;
            endcase
            sel = (op == OP_SLL || op == OP_SRL || op == OP_SRA) ? SEL_SHIFT : SEL_LOGIC;
            a = $urandom;
            b = $urandom;
            apply_op("random", op, sel, a, b, model(op, sel, a, b));
        end

`ifdef EX_DIV_EN
        run_div("divu_100_7",   OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       33);
        run_div("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_div("div_min_m1",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33);
        run_div("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
        run_div("divu_big",     OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1,        33);
        run_div("divu_f_10",    OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33);
        run_div("div_zero",     OP_DIV,  32'd55,       32'd0,        32'd0,        32'd0,        2);
        aluop_i = OP_OR;
        #1;
        expect_eq("hilo_single_pulse", 32'(hilo_we_o), 32'd0);
        next_cycle();
        abort_div("annul", 1'b0);
        abort_div("reset", 1'b1);
        run_div("divu_after_abort", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
`else
        aluop_i  = OP_DIVU;
        alusel_i = SEL_NOP;
        reg1_i   = 32'd100;
        reg2_i   = 32'd7;
        wreg_i   = 1'b1;
        bad      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (|{stallreq_o, hilo_we_o, hi_o, lo_o, wreg_o, wdata_o} !== 1'b0) bad = 1'b1;
            next_cycle();
        end
        expect_eq("nodiv_outputs_zero", 32'(bad), 32'd0);
`endif
        expect_eq("scoreboard_drained", 32'(exp_q.size() + div_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
